// File: rtl/uart_tx_retrans.sv
// uart_tx_retrans
//   Even-parity UART transmitter that holds each byte until it is acknowledged
//   and can replay it on request from the receive side.
//   Frame on the line: start(0), D0..D7 (LSB first), P = ^data, stop(1).
//   Each bit is held for CLKS_PER_BIT cycles.
//
//   Optional feature macro: UART_TX_RETRY_LIMIT_EN
//     defined   : a resend request at retry_count == MAX_RETRIES abandons the
//                 byte, pulses give_up and returns to idle.
//     undefined : resends are unlimited, retry_count saturates at 15,
//                 give_up is tied low and MAX_RETRIES is unused.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   data_in[7:0]   byte to send, sampled when send is accepted
//   send           transmit request, accepted only while ready
//   request_resend replay request, honoured only while waiting for ack
//   ack            frame accepted by receiver, honoured only while waiting
//   signal         registered serial line, idles high
//   ready          high in idle
//   busy           high while a frame is on the line
//   retry_count    resends issued for the current byte
//   give_up        one-cycle pulse when a byte is abandoned
module uart_tx_retrans #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       send,
  input  logic       request_resend,
  input  logic       ack,
  output logic       signal,
  output logic       ready,
  output logic       busy,
  output logic [3:0] retry_count,
  output logic       give_up
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_ACK
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef UART_TX_RETRY_LIMIT_EN
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);
`endif

  state_t      state;
  logic [7:0]  hold_reg;
  logic [2:0]  bit_idx;
  logic [15:0] baud_cnt;
  logic        baud_done;
  logic [2:0]  bit_nxt;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign bit_nxt   = bit_idx + 3'd1;

`ifndef UART_TX_RETRY_LIMIT_EN
  assign give_up = 1'b0;
`endif

  // signal is registered: each transition loads the line value of the bit
  // the next state will present, so the line changes together with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      hold_reg    <= 8'h00;
      bit_idx     <= 3'd0;
      baud_cnt    <= 16'd0;
      signal      <= 1'b1;
      ready       <= 1'b1;
      busy        <= 1'b0;
      retry_count <= 4'd0;
`ifdef UART_TX_RETRY_LIMIT_EN
      give_up     <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_RETRY_LIMIT_EN
      give_up <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (send) begin
            hold_reg    <= data_in;
            retry_count <= 4'd0;
            baud_cnt    <= 16'd0;
            signal      <= 1'b0;
            ready       <= 1'b0;
            busy        <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            signal   <= hold_reg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              signal <= ^hold_reg;
              state  <= S_PARITY;
            end else begin
              bit_idx <= bit_nxt;
              signal  <= hold_reg[bit_nxt];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= 16'd0;
            signal   <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= 16'd0;
            busy     <= 1'b0;
            state    <= S_WAIT_ACK;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_WAIT_ACK: begin
          // ack has priority over a simultaneous resend request
          if (ack) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end else if (request_resend) begin
`ifdef UART_TX_RETRY_LIMIT_EN
            if (retry_count == RETRY_LIMIT) begin
              give_up <= 1'b1;
              ready   <= 1'b1;
              state   <= S_IDLE;
            end else begin
              retry_count <= retry_count + 4'd1;
`else
            begin
              if (retry_count != 4'hF) retry_count <= retry_count + 4'd1;
`endif
              // replay hold_reg untouched
              baud_cnt <= 16'd0;
              signal   <= 1'b0;
              busy     <= 1'b1;
              state    <= S_START;
            end
          end
        end
        default: begin
          signal <= 1'b1;
          ready  <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_retrans.sv
// Bench for uart_tx_retrans: one instance at 1 clock/bit, one at 4 clocks/bit.
// Stimulus pushes expected line frames into per-instance queues; a monitor
// deserialises the line whenever busy is high and compares against the queue.
module tb_uart_tx_retrans;

  localparam int MAX_R = 3;

  logic       clk = 1'b0;
  logic       rst1 = 1'b1, send1 = 1'b0, rr1 = 1'b0, ack1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic       sig1, rdy1, bsy1, gu1;
  logic [3:0] rc1;
  logic       rst4 = 1'b1, send4 = 1'b0, rr4 = 1'b0, ack4 = 1'b0;
  logic [7:0] data4 = 8'h00;
  logic       sig4, rdy4, bsy4, gu4;
  logic [3:0] rc4;

  always #5 clk = ~clk;

  uart_tx_retrans #(.CLKS_PER_BIT(1), .MAX_RETRIES(MAX_R)) dut1 (
    .clk(clk), .reset(rst1), .data_in(data1), .send(send1),
    .request_resend(rr1), .ack(ack1), .signal(sig1), .ready(rdy1),
    .busy(bsy1), .retry_count(rc1), .give_up(gu1));

  uart_tx_retrans #(.CLKS_PER_BIT(4), .MAX_RETRIES(MAX_R)) dut4 (
    .clk(clk), .reset(rst4), .data_in(data4), .send(send4),
    .request_resend(rr4), .ack(ack4), .signal(sig4), .ready(rdy4),
    .busy(bsy4), .retry_count(rc4), .give_up(gu4));

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q1[$];
  logic [10:0] exp_q4[$];

  // reference model state for dut1
  int         m_retry = 0;
  logic [7:0] m_hold  = 8'h00;

  // Line image of a frame, index 0 is the first bit on the wire.
  function automatic logic [10:0] frame(input logic [7:0] d);
    logic p;
    p = ($countones(d) % 2) == 1;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  bit          m_act[2] = '{0, 0};
  int          m_cnt[2];
  bit          m_bad[2];
  logic [10:0] m_rec[2];

  task automatic mon_finish(input int d);
    logic [10:0] e;
    int cpb;
    cpb = (d == 0) ? 1 : 4;
    if ((d == 0 && exp_q1.size() == 0) || (d == 1 && exp_q4.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame dut%0d: got %0h expected none", cpb, m_rec[d]);
    end else begin
      e = (d == 0) ? exp_q1.pop_front() : exp_q4.pop_front();
      chk($sformatf("frame_bits_dut%0d", cpb), 32'(m_rec[d]), 32'(e));
      chk($sformatf("frame_len_dut%0d", cpb), m_cnt[d], 11 * cpb);
      chk($sformatf("bit_stable_dut%0d", cpb), 32'(m_bad[d]), 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic r, s, b;
        int cpb, j;
        r = (d == 0) ? rst1 : rst4;
        s = (d == 0) ? sig1 : sig4;
        b = (d == 0) ? bsy1 : bsy4;
        cpb = (d == 0) ? 1 : 4;
        if (r) m_act[d] = 0;  // frame dropped by reset
        else begin
          if (m_act[d] && !b) begin
            m_act[d] = 0;
            mon_finish(d);
          end
          if (!m_act[d] && b) begin
            m_act[d] = 1;
            m_cnt[d] = 0;
            m_bad[d] = 0;
            m_rec[d] = '1;
          end
          if (m_act[d] && b) begin
            j = m_cnt[d] / cpb;
            if (j < 11) begin
              if (m_cnt[d] % cpb == 0) m_rec[d][j] = s;
              else if (s !== m_rec[d][j]) m_bad[d] = 1;
            end
            m_cnt[d]++;
          end
        end
      end
    end
  end

  // ---------------- dut1 stimulus ----------------
  // Called at the negedge of the first busy cycle; runs to WAIT_ACK.
  task automatic wait_frame(input bit noise);
    int n;
    n = 0;
    while (bsy1 && n < 100) begin
      ack1 = 1'b0; rr1 = 1'b0; send1 = 1'b0;
      if (noise && n < 8) begin
        if (n == 3) ack1 = 1'b1;
        else if ($urandom_range(0, 2) == 0) begin
          ack1  = 1'($urandom);
          rr1   = 1'($urandom);
          send1 = 1'($urandom);
          data1 = 8'($urandom);
        end
      end
      n++;
      @(negedge clk);
    end
    ack1 = 1'b0; rr1 = 1'b0; send1 = 1'b0;
    chk("busy_cycles", n, 11);
    chk("wait_ack_ready", 32'(rdy1), 0);
    chk("wait_ack_line", 32'(sig1), 1);
  endtask

  task automatic do_send(input logic [7:0] d, input bit noise);
    int n;
    n = 0;
    tick();
    while (!rdy1 && n < 50) begin tick(); n++; end
    chk("ready_before_send", 32'(rdy1), 1);
    data1 = d; send1 = 1'b1;
    m_retry = 0; m_hold = d;
    exp_q1.push_back(frame(d));
    tick();
    send1 = 1'b0; data1 = 8'($urandom);
    @(negedge clk);
    chk("ready_fall", 32'(rdy1), 0);
    chk("busy_rise", 32'(bsy1), 1);
    chk("start_bit", 32'(sig1), 0);
    chk("retry_clear", 32'(rc1), 0);
    wait_frame(noise);
  endtask

  task automatic do_ack(input bit both);
    repeat ($urandom_range(0, 3)) tick();
    tick();
    ack1 = 1'b1; rr1 = both;
    tick();
    ack1 = 1'b0; rr1 = 1'b0;
    @(negedge clk);
    chk("ack_ready", 32'(rdy1), 1);
    chk("ack_busy", 32'(bsy1), 0);
    chk("ack_line", 32'(sig1), 1);
    chk("ack_retry", 32'(rc1), 32'(m_retry));
    chk("ack_give_up", 32'(gu1), 0);
    @(negedge clk);
    chk("ack_no_replay", 32'(bsy1), 0);
  endtask

  task automatic do_resend(output bit gave_up);
    repeat ($urandom_range(0, 2)) tick();
    tick();
    rr1 = 1'b1;
    tick();
    rr1 = 1'b0;
    gave_up = 1'b0;
`ifdef UART_TX_RETRY_LIMIT_EN
    if (m_retry == MAX_R) gave_up = 1'b1;
`endif
    if (!gave_up) begin
      if (m_retry < 15) m_retry++;
      exp_q1.push_back(frame(m_hold));
    end
    @(negedge clk);
    chk("give_up", 32'(gu1), 32'(gave_up));
    chk("resend_retry", 32'(rc1), 32'(m_retry));
    if (gave_up) begin
      chk("give_up_ready", 32'(rdy1), 1);
      chk("give_up_busy", 32'(bsy1), 0);
      @(negedge clk);
      chk("give_up_pulse_len", 32'(gu1), 0);
    end else begin
      chk("resend_start", 32'(sig1), 0);
      chk("resend_busy", 32'(bsy1), 1);
      wait_frame(1'b0);
    end
  endtask

  initial begin
    bit g;
    int n;
    // reset values
    repeat (3) tick();
    @(negedge clk);
    chk("rst_signal1", 32'(sig1), 1);
    chk("rst_ready1", 32'(rdy1), 1);
    chk("rst_busy1", 32'(bsy1), 0);
    chk("rst_retry1", 32'(rc1), 0);
    chk("rst_give_up1", 32'(gu1), 0);
    chk("rst_signal4", 32'(sig4), 1);
    chk("rst_ready4", 32'(rdy4), 1);
    chk("rst_busy4", 32'(bsy4), 0);
    tick();
    rst1 = 1'b0; rst4 = 1'b0;

    // directed
    do_send(8'hA5, 1'b0); do_ack(1'b0);
    do_send(8'h07, 1'b1); do_ack(1'b0);
    do_send(8'h3C, 1'b0); do_resend(g); do_ack(1'b0);
    do_send(8'h55, 1'b0);
    g = 1'b0;
    for (int i = 0; i < 4 && !g; i++) do_resend(g);
    if (!g) do_ack(1'b0);
    do_send(8'h96, 1'b0); do_ack(1'b1);
    do_send(8'hC3, 1'b0);
    g = 1'b0;
    for (int i = 0; i < 17 && !g; i++) do_resend(g);
    if (!g) do_ack(1'b0);

    // randomized
    for (int t = 0; t < 20; t++) begin
      do_send(8'($urandom), 1'($urandom));
      g = 1'b0;
      for (int i = $urandom_range(0, 4); i > 0 && !g; i--) do_resend(g);
      if (!g) do_ack($urandom_range(0, 3) == 0);
    end

    // dut4: reset during D3, then a clean frame
    tick();
    data4 = 8'h81; send4 = 1'b1;
    tick();
    send4 = 1'b0;
    repeat (17) tick();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    @(negedge clk);
    chk("midrst_signal4", 32'(sig4), 1);
    chk("midrst_ready4", 32'(rdy4), 1);
    chk("midrst_busy4", 32'(bsy4), 0);
    chk("midrst_retry4", 32'(rc4), 0);
    tick();
    data4 = 8'h81; send4 = 1'b1;
    exp_q4.push_back(frame(8'h81));
    tick();
    send4 = 1'b0;
    @(negedge clk);
    n = 0;
    while (bsy4 && n < 200) begin n++; @(negedge clk); end
    chk("busy_cycles4", n, 44);
    tick();
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    @(negedge clk);
    chk("ack_ready4", 32'(rdy4), 1);

    repeat (5) tick();
    chk("exp_q1_drained", exp_q1.size(), 0);
    chk("exp_q4_drained", exp_q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
